alu_ext: RTL and testbench

Parametrised next-generation accumulator ALU for the simple RISC CPU datapath. It extends the 3-bit opcode set to a 4-bit one, which adds SUB, ADC, shifts, OR, CMP and an iterative shift-add multiplier. It keeps registered status flags (carry, negative, overflow) and reports completion through a busy/done handshake, so the controller can stall during multi-cycle operations. It sits between the accumulator/memory data bus and the accumulator write-back path.

---
 rtl/alu_ext.sv | 174 +++++++++++++++++
 tb/tb_alu_ext.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_ext.sv
// Accumulator ALU with a 4-bit opcode set, registered carry/neg/ovf flags and an
// iterative shift-add multiplier. A busy/done handshake lets the controller stall.
module alu_ext #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_ena,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  // Handshake: an op is accepted on a rising edge where alu_ena=1 and busy=0;
  // done pulses for exactly one cycle when its result and flags are visible.
  // Strobes seen while busy=1 are dropped, never queued.
  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     alu_q, alu_d;
  logic                 carry_q, carry_d, neg_q, neg_d, ovf_q, ovf_d, done_q, done_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d, mcand_q, mcand_d, prod_step;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH:0]       add_r, sub_r;
  logic                 add_ovf, sub_ovf;

  assign add_r   = {1'b0, acc_out} + {1'b0, data}
                 + {{WIDTH{1'b0}}, (opcode == 4'd9) & carry_q};
  assign sub_r   = {1'b0, acc_out} - {1'b0, data};
  assign add_ovf = (acc_out[MSB] == data[MSB]) && (add_r[MSB] != acc_out[MSB]);
  assign sub_ovf = (acc_out[MSB] != data[MSB]) && (sub_r[MSB] != acc_out[MSB]);
  // One multiplier bit per cycle: the shifted multiplicand is added when the
  // current LSB of the (right-shifting) multiplier is set.
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    alu_d    = alu_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (state_q == S_IDLE) begin
      if (alu_ena) begin
        done_d = 1'b1;
        case (opcode)
          4'd0, 4'd1, 4'd6, 4'd7: alu_d = acc_out;
          4'd2, 4'd9: begin
            alu_d   = add_r[MSB:0];
            carry_d = add_r[WIDTH];
            ovf_d   = add_ovf;
            neg_d   = add_r[MSB];
          end
          4'd8: begin
            alu_d   = sub_r[MSB:0];
            carry_d = sub_r[WIDTH];
            ovf_d   = sub_ovf;
            neg_d   = sub_r[MSB];
          end
          4'd14: begin
            carry_d = sub_r[WIDTH];
            ovf_d   = sub_ovf;
            neg_d   = sub_r[MSB];
          end
          4'd3, 4'd4, 4'd12: begin
            if (opcode == 4'd3)      alu_d = acc_out & data;
            else if (opcode == 4'd4) alu_d = acc_out ^ data;
            else                     alu_d = acc_out | data;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            neg_d   = alu_d[MSB];
          end
          4'd5: begin
            alu_d = data;
            neg_d = data[MSB];
          end
          4'd10: begin
            alu_d   = {acc_out[MSB-1:0], 1'b0};
            carry_d = acc_out[MSB];
            neg_d   = acc_out[MSB-1];
          end
          4'd11: begin
            alu_d   = {1'b0, acc_out[MSB:1]};
            carry_d = acc_out[0];
            neg_d   = 1'b0;
          end
          4'd13: begin
            if (MUL_EN) begin
              done_d   = 1'b0;
              state_d  = S_MUL;
              prod_d   = '0;
              mcand_d  = {{WIDTH{1'b0}}, data};
              mplier_d = acc_out;
              cnt_d    = '0;
            end else begin
              alu_d   = '0;
              carry_d = 1'b0;
              neg_d   = 1'b0;
              ovf_d   = 1'b0;
            end
          end
          default: begin
            alu_d   = '0;
            carry_d = 1'b0;
            neg_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        endcase
      end
    end else begin
      prod_d   = prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        alu_d   = prod_step[MSB:0];
        carry_d = |prod_step[2*WIDTH-1:WIDTH];
        neg_d   = prod_step[MSB];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      alu_q    <= '0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      alu_q    <= alu_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign alu_out = alu_q;
  assign carry   = carry_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;
  assign done    = done_q;
  assign busy    = (state_q == S_MUL);
  assign zero    = (acc_out == '0);

endmodule

// File: tb/tb_alu_ext.sv
// Directed bench for alu_ext: an 8-bit instance with MUL and a 16-bit instance
// without it, checked against hand-computed results.
module tb_alu_ext;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_ena, alu_ena16;
  logic [3:0]  opcode, opcode16;
  logic [7:0]  data, acc_out, alu_out;
  logic [15:0] data16, acc16, alu_out16;
  logic        zero, carry, neg, ovf, busy, done;
  logic        zero16, carry16, neg16, ovf16, busy16, done16;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  alu_ext #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .alu_ena(alu_ena), .opcode(opcode), .data(data),
    .acc_out(acc_out), .alu_out(alu_out), .zero(zero), .carry(carry), .neg(neg),
    .ovf(ovf), .busy(busy), .done(done)
  );

  alu_ext #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .alu_ena(alu_ena16), .opcode(opcode16), .data(data16),
    .acc_out(acc16), .alu_out(alu_out16), .zero(zero16), .carry(carry16), .neg(neg16),
    .ovf(ovf16), .busy(busy16), .done(done16)
  );

  // Called just after a falling edge; returns after the accepting edge E0.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_ena = 1'b1; opcode = op; acc_out = a; data = b;
    @(negedge clk);
    alu_ena = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    alu_ena16 = 1'b1; opcode16 = op; acc16 = a; data16 = b;
    @(negedge clk);
    alu_ena16 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (alu_out !== 8'h00) begin bad++; $display("FAIL rst_alu got=%h exp=00", alu_out); end
    total++; if ({carry, neg, ovf, busy, done} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b exp=00000", {carry, neg, ovf, busy, done}); end
    total++; if ({alu_out16, carry16, neg16, ovf16, busy16, done16} !== 21'b0) begin bad++; $display("FAIL rst_w16 got=%h exp=0", {alu_out16, carry16, neg16, ovf16, busy16, done16}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_adc;
    issue(4'd2, 8'hFF, 8'h01);
    total++; if (alu_out !== 8'h00) begin bad++; $display("FAIL add_res got=%h exp=00", alu_out); end
    total++; if ({carry, neg, ovf, done} !== 4'b1001) begin bad++; $display("FAIL add_flags got=%b exp=1001", {carry, neg, ovf, done}); end
    issue(4'd9, 8'h10, 8'h01);
    total++; if (alu_out !== 8'h12) begin bad++; $display("FAIL adc_res got=%h exp=12", alu_out); end
    total++; if ({carry, neg, ovf, done} !== 4'b0001) begin bad++; $display("FAIL adc_flags got=%b exp=0001", {carry, neg, ovf, done}); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_ovf_sub;
    issue(4'd2, 8'h7F, 8'h01);
    total++; if (alu_out !== 8'h80) begin bad++; $display("FAIL addovf_res got=%h exp=80", alu_out); end
    total++; if ({carry, neg, ovf, done} !== 4'b0111) begin bad++; $display("FAIL addovf_flags got=%b exp=0111", {carry, neg, ovf, done}); end
    issue(4'd8, 8'h03, 8'h05);
    total++; if (alu_out !== 8'hFE) begin bad++; $display("FAIL sub_res got=%h exp=fe", alu_out); end
    total++; if ({carry, neg, ovf, done} !== 4'b1101) begin bad++; $display("FAIL sub_flags got=%b exp=1101", {carry, neg, ovf, done}); end
  endtask

  task automatic test_back_to_back;
    issue(4'd5, 8'h00, 8'h80);
    total++; if ({alu_out, carry, neg, ovf, done} !== {8'h80, 4'b1101}) begin bad++; $display("FAIL lda got=%h exp=%h", {alu_out, carry, neg, ovf, done}, {8'h80, 4'b1101}); end
    issue(4'd14, 8'h05, 8'h05);
    total++; if ({alu_out, carry, neg, ovf, done} !== {8'h80, 4'b0001}) begin bad++; $display("FAIL cmp got=%h exp=%h", {alu_out, carry, neg, ovf, done}, {8'h80, 4'b0001}); end
    issue(4'd10, 8'h81, 8'h00);
    total++; if ({alu_out, carry, neg, ovf, done} !== {8'h02, 4'b1001}) begin bad++; $display("FAIL shl got=%h exp=%h", {alu_out, carry, neg, ovf, done}, {8'h02, 4'b1001}); end
    issue(4'd11, 8'h03, 8'h00);
    total++; if ({alu_out, carry, neg, ovf, done} !== {8'h01, 4'b1001}) begin bad++; $display("FAIL shr got=%h exp=%h", {alu_out, carry, neg, ovf, done}, {8'h01, 4'b1001}); end
    issue(4'd12, 8'hF0, 8'h0F);
    total++; if ({alu_out, carry, neg, ovf, done} !== {8'hFF, 4'b0101}) begin bad++; $display("FAIL or got=%h exp=%h", {alu_out, carry, neg, ovf, done}, {8'hFF, 4'b0101}); end
    issue(4'd4, 8'hF0, 8'h3C);
    total++; if ({alu_out, carry, neg, ovf, done} !== {8'hCC, 4'b0101}) begin bad++; $display("FAIL xor got=%h exp=%h", {alu_out, carry, neg, ovf, done}, {8'hCC, 4'b0101}); end
    issue(4'd3, 8'hF0, 8'h3C);
    total++; if ({alu_out, carry, neg, ovf, done} !== {8'h30, 4'b0001}) begin bad++; $display("FAIL and got=%h exp=%h", {alu_out, carry, neg, ovf, done}, {8'h30, 4'b0001}); end
    issue(4'd6, 8'h95, 8'h00);
    total++; if ({alu_out, carry, neg, ovf, done} !== {8'h95, 4'b0001}) begin bad++; $display("FAIL sto got=%h exp=%h", {alu_out, carry, neg, ovf, done}, {8'h95, 4'b0001}); end
  endtask

  task automatic test_mul;
    int dones;
    int lat;
    issue(4'd13, 8'h12, 8'h10);
    total++; if ({busy, done, alu_out} !== {2'b10, 8'h95}) begin bad++; $display("FAIL mul_e0 got=%h exp=%h", {busy, done, alu_out}, {2'b10, 8'h95}); end
    dones = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (i == 2) begin alu_ena = 1'b1; opcode = 4'd2; acc_out = 8'h01; data = 8'h01; end
      if (i == 3) alu_ena = 1'b0;
      total++; if (busy !== (i < 8)) begin bad++; $display("FAIL mul_busy_%0d got=%b exp=%b", i, busy, (i < 8)); end
      if (i < 8) begin
        total++; if (alu_out !== 8'h95) begin bad++; $display("FAIL mul_hold_%0d got=%h exp=95", i, alu_out); end
      end
      if (i == 8) begin
        total++; if ({alu_out, carry, neg, ovf, done} !== {8'h20, 4'b1001}) begin bad++; $display("FAIL mul_res got=%h exp=%h", {alu_out, carry, neg, ovf, done}, {8'h20, 4'b1001}); end
      end
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL mul_dones got=%0d exp=1", dones); end
    issue(4'd13, 8'h0F, 8'h0F);
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    total++; if (lat !== 8) begin bad++; $display("FAIL mul2_latency got=%0d exp=8", lat); end
    total++; if ({alu_out, carry, neg, ovf, done} !== {8'hE1, 4'b0101}) begin bad++; $display("FAIL mul2_res got=%h exp=%h", {alu_out, carry, neg, ovf, done}, {8'hE1, 4'b0101}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul;
    int dones;
    issue(4'd13, 8'h03, 8'h03);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if ({alu_out, carry, neg, ovf, busy, done} !== 13'b0) begin bad++; $display("FAIL midrst got=%h exp=0", {alu_out, carry, neg, ovf, busy, done}); end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrst_nodone got=%0d exp=0", dones); end
    total++; if (alu_out !== 8'h00) begin bad++; $display("FAIL midrst_alu got=%h exp=00", alu_out); end
  endtask

  task automatic test_op15_zero;
    issue(4'd2, 8'h7F, 8'h01);
    issue(4'd15, 8'h55, 8'hAA);
    total++; if ({alu_out, carry, neg, ovf, done} !== {8'h00, 4'b0001}) begin bad++; $display("FAIL op15 got=%h exp=%h", {alu_out, carry, neg, ovf, done}, {8'h00, 4'b0001}); end
    acc_out = 8'h00;
    #1;
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL zero_hi got=%b exp=1", zero); end
    acc_out = 8'h40;
    #1;
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL zero_lo got=%b exp=0", zero); end
    @(negedge clk);
  endtask

  task automatic test_w16;
    int busies;
    issue16(4'd2, 16'hFFFF, 16'h0001);
    total++; if ({alu_out16, carry16, neg16, ovf16, done16} !== {16'h0000, 4'b1001}) begin bad++; $display("FAIL w16_add got=%h exp=%h", {alu_out16, carry16, neg16, ovf16, done16}, {16'h0000, 4'b1001}); end
    issue16(4'd2, 16'h7000, 16'h1234);
    total++; if ({alu_out16, carry16, neg16, ovf16, done16} !== {16'h8234, 4'b0111}) begin bad++; $display("FAIL w16_add2 got=%h exp=%h", {alu_out16, carry16, neg16, ovf16, done16}, {16'h8234, 4'b0111}); end
    issue16(4'd13, 16'h0012, 16'h0010);
    total++; if ({alu_out16, carry16, neg16, ovf16, busy16, done16} !== {16'h0000, 5'b00001}) begin bad++; $display("FAIL w16_mulres got=%h exp=%h", {alu_out16, carry16, neg16, ovf16, busy16, done16}, {16'h0000, 5'b00001}); end
    busies = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy16) busies++;
    end
    total++; if (busies !== 0) begin bad++; $display("FAIL w16_nobusy got=%0d exp=0", busies); end
  endtask

  initial begin
    alu_ena = 1'b0; opcode = 4'd0; data = 8'h00; acc_out = 8'h00;
    alu_ena16 = 1'b0; opcode16 = 4'd0; data16 = 16'h0; acc16 = 16'h0;
    test_reset();
    test_add_adc();
    test_ovf_sub();
    test_back_to_back();
    test_mul();
    test_reset_mid_mul();
    test_op15_zero();
    test_w16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
